// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Reads a burst of bytes from an attached single-port RAM (one-cycle read
// latency) and presents them in address order on a valid/ready byte stream.
// A two-entry output buffer (head + spare) absorbs consumer back-pressure.
// Reads are only issued when the buffer is guaranteed to have room for the
// byte once it returns.
//
// Optional feature: define RAM_STREAM_READER_LAST_EN to add the m_last
// output. m_last marks the final byte of each burst.
module ram_stream_reader #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clka,
   input  logic          rsta_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   length,
   output logic [AW-1:0] addra,
   input  logic [7:0]    douta,
   output logic [7:0]    m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          busy,
   output logic          done
`ifdef RAM_STREAM_READER_LAST_EN
   ,
   output logic          m_last
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [AW-1:0] ADDR_ONE = AW'(1'b1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
   localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);

   state_t        state_q, state_d;

   // Burst bookkeeping
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   issued_q, issued_d;
   logic [AW:0]   sent_q, sent_d;
   logic          pend_q;            // a read was issued last cycle; douta is valid now

   // Two-entry output buffer: head drives the stream, spare catches one extra byte
   logic [7:0]    head_q, head_d;
   logic          head_v_q, head_v_d;
   logic [7:0]    spare_q, spare_d;
   logic          spare_v_q, spare_v_d;

   logic          busy_q;
   logic          done_q;

   // Control strobes derived from the current state
   logic          accept_s;
   logic          zero_start_s;
   logic          issue_s;
   logic          xfer_s;
   logic          last_xfer_s;
   logic [1:0]    occ_s;

   // State register.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: leave FETCH on the last issued read, leave DRAIN on the last transfer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (issue_s && ((issued_q + CNT_ONE) == len_q)) begin
               state_d = DRAIN;
            end else begin
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (last_xfer_s) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output/control decode: start acceptance, read issue throttle, final-transfer detect.
   always_comb begin
      accept_s     = 1'b0;
      zero_start_s = 1'b0;
      issue_s      = 1'b0;
      last_xfer_s  = 1'b0;
      xfer_s       = head_v_q && m_ready;
      // Bytes buffered or in flight that will still be held after this cycle.
      // xfer_s implies head_v_q, so the subtraction cannot underflow.
      occ_s        = {1'b0, head_v_q} + {1'b0, spare_v_q} + {1'b0, pend_q} - {1'b0, xfer_s};
      case (state_q)
         IDLE: begin
            accept_s     = start && (length != CNT_ZERO);
            zero_start_s = start && (length == CNT_ZERO);
         end
         FETCH: begin
            issue_s = (occ_s < 2'd2) && (issued_q < len_q);
         end
         DRAIN: begin
            last_xfer_s = xfer_s && (sent_q == (len_q - CNT_ONE));
         end
         default: begin
            issue_s = 1'b0;
         end
      endcase
   end

   // Counter and address next-state: load on accepted start, advance on issue/transfer.
   always_comb begin
      addr_d   = addr_q;
      len_d    = len_q;
      issued_d = issued_q;
      sent_d   = sent_q;
      if (accept_s) begin
         addr_d   = base_addr;
         len_d    = length;
         issued_d = CNT_ZERO;
         sent_d   = CNT_ZERO;
      end else begin
         if (issue_s) begin
            // DEPTH is a power of two, so the natural AW-bit wrap gives DEPTH-1 -> 0.
            addr_d   = addr_q + ADDR_ONE;
            issued_d = issued_q + CNT_ONE;
         end else begin
            addr_d   = addr_q;
            issued_d = issued_q;
         end
         if (xfer_s) begin
            sent_d = sent_q + CNT_ONE;
         end else begin
            sent_d = sent_q;
         end
      end
   end

   // Output buffer next-state: refill head from spare first so bytes stay in address order.
   always_comb begin
      head_d    = head_q;
      head_v_d  = head_v_q;
      spare_d   = spare_q;
      spare_v_d = spare_v_q;
      if (!head_v_q || xfer_s) begin
         if (spare_v_q) begin
            head_d   = spare_q;
            head_v_d = 1'b1;
            if (pend_q) begin
               spare_d   = douta;
               spare_v_d = 1'b1;
            end else begin
               spare_v_d = 1'b0;
            end
         end else if (pend_q) begin
            head_d    = douta;
            head_v_d  = 1'b1;
            spare_v_d = 1'b0;
         end else begin
            head_v_d  = 1'b0;
            spare_v_d = 1'b0;
         end
      end else begin
         // Head is stalled; the issue throttle guarantees the spare is free here.
         if (pend_q) begin
            spare_d   = douta;
            spare_v_d = 1'b1;
         end else begin
            spare_v_d = spare_v_q;
         end
      end
   end

   // Datapath registers: counters, buffer, and the registered busy/done flags.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         addr_q    <= {AW{1'b0}};
         len_q     <= CNT_ZERO;
         issued_q  <= CNT_ZERO;
         sent_q    <= CNT_ZERO;
         pend_q    <= 1'b0;
         head_q    <= 8'h00;
         head_v_q  <= 1'b0;
         spare_q   <= 8'h00;
         spare_v_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         len_q     <= len_d;
         issued_q  <= issued_d;
         sent_q    <= sent_d;
         pend_q    <= issue_s;
         head_q    <= head_d;
         head_v_q  <= head_v_d;
         spare_q   <= spare_d;
         spare_v_q <= spare_v_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= zero_start_s || last_xfer_s;
      end
   end

`ifdef RAM_STREAM_READER_LAST_EN
   logic m_last_q;

   // Final-byte marker, registered alongside the head entry it describes.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         m_last_q <= 1'b0;
      end else begin
         m_last_q <= head_v_d && (sent_d == (len_q - CNT_ONE));
      end
   end

   assign m_last = m_last_q;
`endif

   assign addra   = addr_q;
   assign m_data  = head_q;
   assign m_valid = head_v_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM, random consumer back-pressure,
// expected bytes taken from the RAM image at (base + k) mod DEPTH.
module tb_ram_stream_reader;

   localparam int DEPTH = 1024;
   localparam int AW    = $clog2(DEPTH);

   logic          clka = 1'b0;
   logic          rsta_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic [AW-1:0] addra;
   logic [7:0]    douta;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_ready;
   logic          busy;
   logic          done;
`ifdef RAM_STREAM_READER_LAST_EN
   logic          m_last;
`endif

   ram_stream_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clka      (clka),
      .rsta_n    (rsta_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .addra     (addra),
      .douta     (douta),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .busy      (busy),
`ifdef RAM_STREAM_READER_LAST_EN
      .done      (done),
      .m_last    (m_last)
`else
      .done      (done)
`endif
   );

   always #5 clka = ~clka;

   // RAM model with one-cycle read latency
   logic [7:0] mem [DEPTH];
   always @(posedge clka) douta <= mem[addra];

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Observations from the last burst
   logic [7:0] got_q[$];
   int first_valid_cyc, done_cyc, done_cnt, busy_cnt, stall_bad, last_bad, last_cnt, last_idx;
   bit timed_out;

   // Drive one burst starting at the current negedge and record what the stream produced.
   task automatic run_burst(input int base, input int len, input int pct, input int inj_cyc);
      logic pv, pr, r;
      logic [7:0] pd;
      int limit;
      got_q.delete();
      first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
      stall_bad = 0; last_bad = 0; last_cnt = 0; last_idx = -1;
      pv = 1'b0; pr = 1'b0; pd = 8'h00;
      limit = 20 * len + 60;
      base_addr = base[AW-1:0];
      length    = len[AW:0];
      start     = 1'b1;
      for (int cyc = 0; cyc < limit; cyc++) begin
         @(negedge clka);
         start = 1'b0;
         if (cyc == inj_cyc) begin
            base_addr = ~base_addr;
            length    = 11'd5;
            start     = 1'b1;
         end
         if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd)) stall_bad++;
`ifdef RAM_STREAM_READER_LAST_EN
         if (m_last === 1'b1 && m_valid !== 1'b1) last_bad++;
`endif
         r = ($urandom_range(99) < pct);
         m_ready = r;
         if (m_valid === 1'b1 && r) begin
`ifdef RAM_STREAM_READER_LAST_EN
            if (m_last === 1'b1) begin
               last_cnt++;
               last_idx = got_q.size();
            end
`endif
            got_q.push_back(m_data);
         end
         pv = (m_valid === 1'b1);
         pr = r;
         pd = m_data;
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      end
      timed_out = (done_cyc < 0);
   endtask

   task automatic test_reset();
      rsta_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      #1;
      total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b want=0", m_valid); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else pass_cnt++;
      total_cnt++; if (addra !== 10'd0) $display("FAIL reset_addra got=%h want=0", addra); else pass_cnt++;
      total_cnt++; if (m_data !== 8'h00) $display("FAIL reset_m_data got=%h want=00", m_data); else pass_cnt++;
      repeat (3) @(negedge clka);
      rsta_n = 1'b1;
      @(negedge clka);
   endtask

   task automatic test_basic();
      run_burst(32'h010, 4, 100, -1);
      total_cnt++; if (timed_out) $display("FAIL basic_timeout no done seen"); else pass_cnt++;
      total_cnt++; if (got_q.size() != 4) $display("FAIL basic_count got=%0d want=4", got_q.size()); else pass_cnt++;
      for (int k = 0; k < 4 && k < got_q.size(); k++) begin
         total_cnt++;
         if (got_q[k] !== 8'(8'h10 + k)) $display("FAIL basic_byte%0d got=%h want=%h", k, got_q[k], 8'(8'h10 + k));
         else pass_cnt++;
      end
      total_cnt++; if (first_valid_cyc != 2) $display("FAIL basic_latency got=%0d want=2", first_valid_cyc); else pass_cnt++;
      total_cnt++; if (done_cyc != 6) $display("FAIL basic_done_cycle got=%0d want=6", done_cyc); else pass_cnt++;
      total_cnt++; if (busy_cnt != 6) $display("FAIL basic_busy_cycles got=%0d want=6", busy_cnt); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_wrap();
      int exp;
      run_burst(DEPTH - 2, 4, 100, -1);
      total_cnt++; if (timed_out) $display("FAIL wrap_timeout no done seen"); else pass_cnt++;
      total_cnt++; if (got_q.size() != 4) $display("FAIL wrap_count got=%0d want=4", got_q.size()); else pass_cnt++;
      for (int k = 0; k < 4 && k < got_q.size(); k++) begin
         exp = int'(mem[(DEPTH - 2 + k) % DEPTH]);
         total_cnt++;
         if (got_q[k] !== exp[7:0]) $display("FAIL wrap_byte%0d got=%h want=%h", k, got_q[k], exp[7:0]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random_ready();
      int base, bad;
      base = int'($urandom_range(DEPTH - 1));
      run_burst(base, 16, 30, -1);
      bad = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] !== mem[(base + k) % DEPTH]) bad++;
      total_cnt++; if (timed_out) $display("FAIL rand_timeout no done seen"); else pass_cnt++;
      total_cnt++; if (got_q.size() != 16) $display("FAIL rand_count got=%0d want=16", got_q.size()); else pass_cnt++;
      total_cnt++; if (bad != 0) $display("FAIL rand_order bad_bytes=%0d want=0", bad); else pass_cnt++;
      total_cnt++; if (stall_bad != 0) $display("FAIL rand_stall_hold violations=%0d want=0", stall_bad); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL rand_done_pulses got=%0d want=1", done_cnt); else pass_cnt++;
   endtask

   task automatic test_zero_len();
      run_burst(int'($urandom_range(DEPTH - 1)), 0, 100, -1);
      total_cnt++; if (done_cyc != 0) $display("FAIL zero_done_cycle got=%0d want=0", done_cyc); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL zero_done_pulses got=%0d want=1", done_cnt); else pass_cnt++;
      total_cnt++; if (busy_cnt != 0) $display("FAIL zero_busy got=%0d want=0", busy_cnt); else pass_cnt++;
      total_cnt++; if (first_valid_cyc != -1) $display("FAIL zero_valid first_at=%0d want=never", first_valid_cyc); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int base, n, dn, exp;
      bit reached;
      base = int'($urandom_range(DEPTH - 1));
      n = 0; dn = 0; reached = 1'b0;
      base_addr = base[AW-1:0]; length = 11'd8; start = 1'b1; m_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && !reached; cyc++) begin
         @(negedge clka);
         start = 1'b0;
         if (m_valid === 1'b1) n++;
         if (n == 3) reached = 1'b1;
      end
      @(negedge clka);
      total_cnt++; if (!reached) $display("FAIL rstmid_progress transfers=%0d want=3", n); else pass_cnt++;
      rsta_n = 1'b0;
      #1;
      total_cnt++; if (m_valid !== 1'b0) $display("FAIL rstmid_m_valid got=%b want=0", m_valid); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy); else pass_cnt++;
      total_cnt++; if (addra !== 10'd0) $display("FAIL rstmid_addra got=%h want=0", addra); else pass_cnt++;
      total_cnt++; if (m_data !== 8'h00) $display("FAIL rstmid_m_data got=%h want=00", m_data); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clka);
         if (done === 1'b1) dn++;
      end
      rsta_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clka);
         if (done === 1'b1) dn++;
      end
      total_cnt++; if (dn != 0) $display("FAIL rstmid_no_done pulses=%0d want=0", dn); else pass_cnt++;
      base = int'($urandom_range(DEPTH - 1));
      run_burst(base, 2, 100, -1);
      total_cnt++; if (got_q.size() != 2) $display("FAIL rstmid_new_count got=%0d want=2", got_q.size()); else pass_cnt++;
      for (int k = 0; k < 2 && k < got_q.size(); k++) begin
         exp = int'(mem[(base + k) % DEPTH]);
         total_cnt++;
         if (got_q[k] !== exp[7:0]) $display("FAIL rstmid_new_byte%0d got=%h want=%h", k, got_q[k], exp[7:0]);
         else pass_cnt++;
      end
      total_cnt++; if (first_valid_cyc != 2) $display("FAIL rstmid_new_latency got=%0d want=2", first_valid_cyc); else pass_cnt++;
   endtask

   task automatic test_busy_start();
      int base, bad;
      base = int'($urandom_range(DEPTH - 1));
      run_burst(base, 3, 60, 1);
      bad = 0;
      for (int k = 0; k < got_q.size(); k++)
         if (got_q[k] !== mem[(base + k) % DEPTH]) bad++;
      total_cnt++; if (got_q.size() != 3) $display("FAIL busystart_count got=%0d want=3", got_q.size()); else pass_cnt++;
      total_cnt++; if (bad != 0) $display("FAIL busystart_data bad_bytes=%0d want=0", bad); else pass_cnt++;
      total_cnt++; if (done_cnt != 1) $display("FAIL busystart_done_pulses got=%0d want=1", done_cnt); else pass_cnt++;
`ifdef RAM_STREAM_READER_LAST_EN
      total_cnt++; if (last_cnt != 1) $display("FAIL last_count got=%0d want=1", last_cnt); else pass_cnt++;
      total_cnt++; if (last_idx != 2) $display("FAIL last_index got=%0d want=2", last_idx); else pass_cnt++;
      total_cnt++; if (last_bad != 0) $display("FAIL last_without_valid got=%0d want=0", last_bad); else pass_cnt++;
`endif
   endtask

   task automatic test_back_to_back();
      int base, len, pct, bad;
      for (int b = 0; b < 7; b++) begin
         base = int'($urandom_range(DEPTH - 1));
         len  = (b == 6) ? DEPTH : int'($urandom_range(40, 1));
         pct  = (b == 6 || b == 0) ? 100 : int'($urandom_range(100, 30));
         run_burst(base, len, pct, -1);
         bad = 0;
         for (int k = 0; k < got_q.size(); k++)
            if (got_q[k] !== mem[(base + k) % DEPTH]) bad++;
         total_cnt++; if (got_q.size() != len) $display("FAIL b2b%0d_count got=%0d want=%0d", b, got_q.size(), len); else pass_cnt++;
         total_cnt++; if (bad != 0) $display("FAIL b2b%0d_data bad_bytes=%0d want=0", b, bad); else pass_cnt++;
         total_cnt++; if (stall_bad != 0) $display("FAIL b2b%0d_stall_hold violations=%0d want=0", b, stall_bad); else pass_cnt++;
         total_cnt++; if (done_cnt != 1) $display("FAIL b2b%0d_done_pulses got=%0d want=1", b, done_cnt); else pass_cnt++;
         if (pct == 100) begin
            total_cnt++;
            if (done_cyc != len + 2) $display("FAIL b2b%0d_throughput done_at=%0d want=%0d", b, done_cyc, len + 2);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = i[7:0];
      test_reset();
      test_basic();
      test_wrap();
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      test_random_ready();
      test_zero_len();
      test_reset_mid();
      test_busy_start();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, words in attached single_port_ram (power of two, >=2).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), address width.
REQ-003 SHALL have port clka  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rsta_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-006 SHALL have port base_addr  input  AW  first RAM address, sampled with start.
REQ-007 SHALL have port length  input  AW+1  byte count, sampled with start, 0..DEPTH.
REQ-008 SHALL have port addra  output  AW  address to single_port_ram.
REQ-009 SHALL have port douta  input  8  read data from single_port_ram, valid one cycle after addra.
REQ-010 SHALL have port m_data  output  8  stream byte.
REQ-011 SHALL have port m_valid  output  1  m_data valid.
REQ-012 SHALL have port m_ready  input  1  consumer accepts; transfer when m_valid && m_ready.
REQ-013 SHALL have port busy  output  1  burst in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse after final transfer.

Function
REQ-015 SHALL implement FSM IDLE -> FETCH -> DRAIN -> IDLE.
REQ-016 IDLE: start with length>0 latches base_addr/length and enters FETCH next cycle; start with length=0 pulses done next cycle, no reads, stays IDLE.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 FETCH: a read is issued in a cycle when (buffer occupancy + reads in flight, less any transfer this cycle) < 2 and issued < length.
REQ-019 Issued read presents next address on addra; captures douta into a 2-entry output buffer exactly one cycle later.
REQ-020 Address SHALL increment by 1 per issued read, wrapping DEPTH-1 -> 0.
REQ-021 FETCH -> DRAIN when issued count equals length; DRAIN -> IDLE on the transfer of the final byte, with done=1 in the following cycle.
REQ-022 Buffer SHALL never overflow or drop/duplicate bytes under any m_ready pattern; bytes emitted in address order.
REQ-023 With m_ready held 1, SHALL sustain one transfer per cycle; first m_valid 2 cycles after start.
REQ-024 m_data/m_valid SHALL be registered outputs; m_data stable while m_valid && !m_ready.
REQ-025 busy SHALL be 1 from the cycle after an accepted start (length>0) until the cycle done is 1, exclusive.
REQ-026 Module SHALL never write the RAM (no write-enable driven).

Reset
REQ-027 rsta_n=0 SHALL immediately force state IDLE, busy=0, done=0, m_valid=0, m_data=0, addra=0, buffer empty, counters 0.
REQ-028 Reset mid-burst SHALL abort without done; first start after rsta_n rises SHALL behave as from power-up.

Configuration
REQ-029 Macro RAM_STREAM_READER_LAST_EN defined: SHALL add port m_last output 1, high with the final byte of a burst while m_valid=1, else 0 (reset 0).
REQ-030 Macro undefined: m_last port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 base_addr=0x010, length=4, m_ready=1, RAM[i]=i -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, done one cycle after last.
REQ-032 base_addr=DEPTH-2, length=4 -> addresses DEPTH-2, DEPTH-1, 0, 1 in order; 4 bytes emitted.
REQ-033 length=16, m_ready toggling random 30% duty -> exactly 16 bytes in order, none lost or repeated, occupancy <=2.
REQ-034 length=0 -> done pulse next cycle, busy stays 0, m_valid never asserted.
REQ-035 rsta_n pulsed low after 3 of 8 bytes -> outputs at reset values immediately, no done; new start length=2 yields 2 correct bytes.
REQ-036 With RAM_STREAM_READER_LAST_EN, length=3 -> m_last high only on third transfer; start during busy ignored.
